lna_power_sequencer: RTL and testbench

- Controls the LNA bipolar supply built from the V+/V- generator, on the 100 MHz link clock.
- Sequences power-up as V+ then V-, each with a PWM soft-start ramp, and confirms each rail through its power-good return.
- Sequences power-down as V- then V+.
- Latches faults, and reports state and fault cause to link/control logic.

---
 rtl/lna_power_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_lna_power_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/lna_power_sequencer.sv
// Bipolar LNA supply sequencer: V+ then V- soft-start power-up with power-good
// confirmation, V- then V+ power-down, and latched fault reporting.
`timescale 1ns/1ps

module lna_power_sequencer #(
    parameter int PWM_BITS    = 8,
    parameter int STEP_CYCLES = 100,
    parameter int PG_TIMEOUT  = 100000,
    parameter int OFF_DELAY   = 1000
) (
    input  logic       Clock100Mhz,
    input  logic       Reset,
    input  logic       Enable,
    input  logic       FaultClear,
    input  logic       PowerGoodPlus,
    input  logic       PowerGoodMinus,
    output logic       EnablePlus,
    output logic       EnableMinus,
    output logic       PwmPlus,
    output logic       PwmMinus,
    output logic       PowerReady,
    output logic       Fault,
    output logic [1:0] FaultCode,
    output logic [2:0] State
);

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_RAMP_P   = 3'd1,
        ST_WAIT_P   = 3'd2,
        ST_RAMP_M   = 3'd3,
        ST_WAIT_M   = 3'd4,
        ST_ON       = 3'd5,
        ST_SHUTDOWN = 3'd6,
        ST_FAULT    = 3'd7
    } state_t;

    localparam int SW   = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int TMAX = (PG_TIMEOUT > OFF_DELAY) ? PG_TIMEOUT : OFF_DELAY;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [PWM_BITS-1:0] DMAX      = '1;
    localparam logic [PWM_BITS-1:0] DUTY_INC  = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] DUTY_LAST = DMAX - DUTY_INC;
    localparam logic [SW-1:0]       STEP_INC  = SW'(1);
    localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_CYCLES - 1);
    localparam logic [TW-1:0]       TIME_INC  = TW'(1);
    localparam logic [TW-1:0]       PG_LAST   = TW'(PG_TIMEOUT - 1);
    localparam logic [TW-1:0]       OFF_LAST  = TW'(OFF_DELAY - 1);

    state_t              state, state_nxt;
    logic [PWM_BITS-1:0] duty_p, duty_p_nxt, duty_m, duty_m_nxt, pwm_cnt;
    logic [SW-1:0]       step_cnt, step_nxt;
    logic [TW-1:0]       timer, timer_nxt;
    logic [1:0]          code, code_nxt;
    logic                pg_p_meta, pg_p, pg_m_meta, pg_m;
    logic                en_p, en_m;

    // Power-good pins come from the rail generator, unrelated to this clock.
    always_ff @(posedge Clock100Mhz or posedge Reset) begin
        if (Reset) begin
            pg_p_meta <= 1'b0;
            pg_p      <= 1'b0;
            pg_m_meta <= 1'b0;
            pg_m      <= 1'b0;
            pwm_cnt   <= '0;
        end else begin
            // NOTE: non-blocking here so each flop samples the previous stage's old value.
            pg_p_meta <= PowerGoodPlus;
            pg_p      <= pg_p_meta;
            pg_m_meta <= PowerGoodMinus;
            pg_m      <= pg_m_meta;
            pwm_cnt   <= pwm_cnt + DUTY_INC;
        end
    end

    always_ff @(posedge Clock100Mhz or posedge Reset) begin
        if (Reset) begin
            state    <= ST_OFF;
            duty_p   <= '0;
            duty_m   <= '0;
            step_cnt <= '0;
            timer    <= '0;
            code     <= 2'd0;
        end else begin
            state    <= state_nxt;
            duty_p   <= duty_p_nxt;
            duty_m   <= duty_m_nxt;
            step_cnt <= step_nxt;
            timer    <= timer_nxt;
            code     <= code_nxt;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_nxt  = state;
        duty_p_nxt = duty_p;
        duty_m_nxt = duty_m;
        step_nxt   = step_cnt;
        timer_nxt  = timer;
        code_nxt   = code;
        case (state)
            ST_OFF: begin
                if (Enable) begin
                    state_nxt = ST_RAMP_P;
                    step_nxt  = '0;
                    timer_nxt = '0;
                end
            end
            ST_RAMP_P, ST_RAMP_M: begin
                if (!Enable) begin
                    state_nxt  = ST_SHUTDOWN;
                    duty_m_nxt = '0;
                    timer_nxt  = '0;
                end else if (step_cnt == STEP_LAST) begin
                    step_nxt  = '0;
                    timer_nxt = '0;
                    if (state == ST_RAMP_P) begin
                        duty_p_nxt = duty_p + DUTY_INC;
                        if (duty_p == DUTY_LAST) state_nxt = ST_WAIT_P;
                    end else begin
                        duty_m_nxt = duty_m + DUTY_INC;
                        if (duty_m == DUTY_LAST) state_nxt = ST_WAIT_M;
                    end
                end else begin
                    step_nxt = step_cnt + STEP_INC;
                end
            end
            ST_WAIT_P, ST_WAIT_M: begin
                if (!Enable) begin
                    state_nxt  = ST_SHUTDOWN;
                    duty_m_nxt = '0;
                    timer_nxt  = '0;
                end else if ((state == ST_WAIT_P) ? pg_p : pg_m) begin
                    state_nxt = (state == ST_WAIT_P) ? ST_RAMP_M : ST_ON;
                    step_nxt  = '0;
                    timer_nxt = '0;
                end else if (timer == PG_LAST) begin
                    state_nxt  = ST_FAULT;
                    code_nxt   = (state == ST_WAIT_P) ? 2'd1 : 2'd2;
                    duty_p_nxt = '0;
                    duty_m_nxt = '0;
                end else begin
                    timer_nxt = timer + TIME_INC;
                end
            end
            ST_ON: begin
                // Rail loss outranks a simultaneous power-down request.
                if (!pg_p || !pg_m) begin
                    state_nxt  = ST_FAULT;
                    code_nxt   = 2'd3;
                    duty_p_nxt = '0;
                    duty_m_nxt = '0;
                end else if (!Enable) begin
                    state_nxt  = ST_SHUTDOWN;
                    duty_m_nxt = '0;
                    timer_nxt  = '0;
                end
            end
            ST_SHUTDOWN: begin
                if (timer == OFF_LAST) begin
                    state_nxt  = ST_OFF;
                    duty_p_nxt = '0;
                    duty_m_nxt = '0;
                end else begin
                    timer_nxt = timer + TIME_INC;
                end
            end
            ST_FAULT: begin
                if (FaultClear && !Enable) begin
                    state_nxt = ST_OFF;
                    code_nxt  = 2'd0;
                end
            end
            default: state_nxt = ST_OFF;
        endcase
    end

    // Outputs decode straight from reset-cleared registers, so Reset drops them at once.
    always_comb begin
        en_p        = state inside {ST_RAMP_P, ST_WAIT_P, ST_RAMP_M, ST_WAIT_M, ST_ON, ST_SHUTDOWN};
        en_m        = state inside {ST_RAMP_M, ST_WAIT_M, ST_ON};
        EnablePlus  = en_p;
        EnableMinus = en_m;
        PwmPlus     = en_p & ((duty_p == DMAX) | (pwm_cnt < duty_p));
        PwmMinus    = en_m & ((duty_m == DMAX) | (pwm_cnt < duty_m));
        PowerReady  = (state == ST_ON);
        Fault       = (state == ST_FAULT);
        FaultCode   = code;
        State       = state;
    end

endmodule

// File: tb/tb_lna_power_sequencer.sv
// Directed bench for lna_power_sequencer with small parameters; expected values
// are hand-derived cycle counts plus a reference PWM counter.
`timescale 1ns/1ps

module tb_lna_power_sequencer;

    logic       clk = 1'b0;
    logic       rst, enable, fault_clear, pg_plus, pg_minus;
    logic       en_plus, en_minus, pwm_plus, pwm_minus, power_ready, fault;
    logic [1:0] fault_code;
    logic [2:0] state;
    logic [7:0] outs;
    logic [3:0] tb_cnt;
    int         vectors = 0;
    int         miscompares = 0;

    lna_power_sequencer #(
        .PWM_BITS(4), .STEP_CYCLES(2), .PG_TIMEOUT(20), .OFF_DELAY(5)
    ) dut (
        .Clock100Mhz   (clk),
        .Reset         (rst),
        .Enable        (enable),
        .FaultClear    (fault_clear),
        .PowerGoodPlus (pg_plus),
        .PowerGoodMinus(pg_minus),
        .EnablePlus    (en_plus),
        .EnableMinus   (en_minus),
        .PwmPlus       (pwm_plus),
        .PwmMinus      (pwm_minus),
        .PowerReady    (power_ready),
        .Fault         (fault),
        .FaultCode     (fault_code),
        .State         (state)
    );

    always #5 clk = ~clk;

    // {EnablePlus, EnableMinus, PwmPlus, PwmMinus, PowerReady, Fault, FaultCode}
    assign outs = {en_plus, en_minus, pwm_plus, pwm_minus, power_ready, fault, fault_code};

    // Reference free-running PWM counter.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_cnt <= 4'd0;
        else     tb_cnt <= tb_cnt + 4'd1;
    end

    function automatic logic exp_pwm(input logic [3:0] duty);
        return (duty == 4'hF) || (tb_cnt < duty);
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
        for (int n = 0; n < budget && state !== target; n++) step();
        check(tag, {5'd0, state}, {5'd0, target});
    endtask

    task automatic power_up(input string tag);
        enable = 1'b1;
        wait_state(3'd2, 40, {tag, "_wait_p"});
        pg_plus = 1'b1;
        wait_state(3'd4, 50, {tag, "_wait_m"});
        pg_minus = 1'b1;
        wait_state(3'd5, 10, {tag, "_on"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; fault_clear = 1'b0; pg_plus = 1'b0; pg_minus = 1'b0;
        #12;
        check("reset_state", {5'd0, state}, 8'd0);
        check("reset_outs", outs, 8'h00);
        @(posedge clk); #3; rst = 1'b0;
        step(); step();
        check("idle_state", {5'd0, state}, 8'd0);
        check("idle_outs", outs, 8'h00);

        // 1: normal power-up
        enable = 1'b1;
        step();
        check("t1_en_m_low", {7'd0, en_minus}, 8'd0);
        for (int i = 0; i < 30; i++) begin
            check("t1_ramp_p_state", {5'd0, state}, 8'd1);
            check("t1_pwm_p", {7'd0, pwm_plus}, {7'd0, exp_pwm(4'(i / 2))});
            step();
        end
        check("t1_wait_p_entry", {5'd0, state}, 8'd2);
        check("t1_pwm_p_full", {7'd0, pwm_plus}, 8'd1);
        repeat (3) step();
        check("t1_wait_p_hold", {5'd0, state}, 8'd2);
        pg_plus = 1'b1;
        step(); check("t1_sync_p1", {5'd0, state}, 8'd2);
        step(); check("t1_sync_p2", {5'd0, state}, 8'd2);
        step(); check("t1_ramp_m_entry", {5'd0, state}, 8'd3);
        for (int i = 0; i < 30; i++) begin
            check("t1_ramp_m_state", {5'd0, state}, 8'd3);
            check("t1_pwm_m", {7'd0, pwm_minus}, {7'd0, exp_pwm(4'(i / 2))});
            check("t1_pwm_p_hold", {7'd0, pwm_plus}, 8'd1);
            step();
        end
        check("t1_wait_m_entry", {5'd0, state}, 8'd4);
        repeat (3) step();
        pg_minus = 1'b1;
        step(); step();
        check("t1_sync_m", {5'd0, state}, 8'd4);
        step();
        check("t1_on_state", {5'd0, state}, 8'd5);
        check("t1_on_outs", outs, 8'hF8);

        // 2: ordered shutdown
        enable = 1'b0;
        step();
        check("t2_sd_state", {5'd0, state}, 8'd6);
        check("t2_sd_outs", outs, 8'hA0);
        for (int k = 1; k <= 4; k++) begin
            step();
            check("t2_sd_hold_state", {5'd0, state}, 8'd6);
            check("t2_sd_hold_outs", outs, 8'hA0);
        end
        step();
        check("t2_off_state", {5'd0, state}, 8'd0);
        check("t2_off_outs", outs, 8'h00);
        pg_plus = 1'b0; pg_minus = 1'b0;

        // 3: V+ power-good timeout
        enable = 1'b1;
        step();
        check("t3_ramp_p", {5'd0, state}, 8'd1);
        repeat (30) step();
        check("t3_wait_p_entry", {5'd0, state}, 8'd2);
        repeat (19) step();
        check("t3_wait_p_19", {5'd0, state}, 8'd2);
        step();
        check("t3_fault_state", {5'd0, state}, 8'd7);
        check("t3_fault_outs", outs, 8'h05);
        fault_clear = 1'b1; step(); fault_clear = 1'b0;
        check("t3_clear_ignored", {5'd0, state}, 8'd7);
        check("t3_clear_ignored_outs", outs, 8'h05);
        enable = 1'b0; fault_clear = 1'b1; step(); fault_clear = 1'b0;
        check("t3_cleared_state", {5'd0, state}, 8'd0);
        check("t3_cleared_outs", outs, 8'h00);

        // 4: rail loss in ON coinciding with Enable=0 at the FSM
        power_up("t4");
        pg_minus = 1'b0;
        step(); check("t4_sync1", {5'd0, state}, 8'd5);
        step(); check("t4_sync2", {5'd0, state}, 8'd5);
        enable = 1'b0;
        step();
        check("t4_fault_state", {5'd0, state}, 8'd7);
        check("t4_fault_outs", outs, 8'h07);
        fault_clear = 1'b1; step(); fault_clear = 1'b0;
        check("t4_cleared", {5'd0, state}, 8'd0);

        // 5: abort mid-ramp at DutyMinus=7
        enable = 1'b1;
        wait_state(3'd3, 40, "t5_ramp_m_entry");
        repeat (14) step();
        check("t5_ramp_m_state", {5'd0, state}, 8'd3);
        check("t5_pwm_m_duty7", {7'd0, pwm_minus}, {7'd0, exp_pwm(4'd7)});
        enable = 1'b0;
        step();
        check("t5_sd_state", {5'd0, state}, 8'd6);
        check("t5_sd_outs", outs, 8'hA0);
        repeat (4) step();
        check("t5_sd_hold", outs, 8'hA0);
        step();
        check("t5_off_state", {5'd0, state}, 8'd0);
        check("t5_off_outs", outs, 8'h00);

        // 6: asynchronous reset in ON
        pg_minus = 1'b1;
        power_up("t6");
        step();
        #3; rst = 1'b1; #1;
        check("t6_async_state", {5'd0, state}, 8'd0);
        check("t6_async_outs", outs, 8'h00);
        enable = 1'b0;
        #2; rst = 1'b0;
        step(); step();
        check("t6_stay_off", {5'd0, state}, 8'd0);
        enable = 1'b1;
        step();
        check("t6_restart", {5'd0, state}, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
